// File: rtl/condlogic_banked_pkg.sv
// Shared types for the conditional-execution unit: condition codes,
// NZCV flag layout and memory-write FSM states.
package condlogic_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wrstate_e;

  // Bank index width, never narrower than one bit.
  function automatic int bank_w(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/condlogic_banked_if.sv
// Controller-side bundle for the conditional-execution unit.
interface condlogic_banked_if
  import condlogic_pkg::*;
#(
  parameter int NBANK = 2
);
  localparam int BW = bank_w(NBANK);

  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS;
  logic          NextPC;
  logic          RegW;
  logic          MemW;
  logic          NoWrite;
  logic          Stall;
  logic [BW-1:0] BankSel;
  logic          FlagSave;
  logic          FlagRestore;

  logic [3:0]    Flags;
  logic          CondEx;
  logic          CondExDelayed;
  logic          PCWrite;
  logic          RegWrite;
  logic          MemWrite;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite,
           Stall, BankSel, FlagSave, FlagRestore,
    input  Flags, CondEx, CondExDelayed, PCWrite, RegWrite, MemWrite
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, NoWrite,
           Stall, BankSel, FlagSave, FlagRestore,
    output Flags, CondEx, CondExDelayed, PCWrite, RegWrite, MemWrite
  );
endinterface

// File: rtl/condlogic_banked_condeval.sv
// Pure combinational ARM condition evaluator; shared with pipelined cores.
module condeval
  import condlogic_pkg::*;
(
  input  logic [3:0] i_cond,
  input  nzcv_t      i_flags,
  output logic       o_condex
);
  // Decode the condition field against the current NZCV.
  always_comb begin
    o_condex = 1'b0;
    case (cond_e'(i_cond))
      EQ: o_condex = i_flags.z;
      NE: o_condex = ~i_flags.z;
      CS: o_condex = i_flags.c;
      CC: o_condex = ~i_flags.c;
      MI: o_condex = i_flags.n;
      PL: o_condex = ~i_flags.n;
      VS: o_condex = i_flags.v;
      VC: o_condex = ~i_flags.v;
      HI: o_condex = i_flags.c & ~i_flags.z;
      LS: o_condex = ~i_flags.c | i_flags.z;
      GE: o_condex = (i_flags.n == i_flags.v);
      LT: o_condex = (i_flags.n != i_flags.v);
      GT: o_condex = ~i_flags.z & (i_flags.n == i_flags.v);
      LE: o_condex = i_flags.z | (i_flags.n != i_flags.v);
      AL: o_condex = 1'b1;
      default: o_condex = 1'b0;
    endcase
  end
endmodule

// File: rtl/condlogic_banked.sv
// Conditional-execution unit with banked NZCV / saved-NZCV registers,
// write-strobe gating and a memory-write hold across AHB stalls.
module condlogic_banked
  import condlogic_pkg::*;
#(
  parameter int NBANK = 2
)(
  input  logic             clk,
  input  logic             reset_n,
  condlogic_banked_if.slave bus
);
  localparam int BW = bank_w(NBANK);

  nzcv_t         r_flags [NBANK];
  nzcv_t         r_saved [NBANK];
  logic          r_condex_d;
  wrstate_e      r_state;

  logic [NBANK-1:0] w_sel;
  nzcv_t         w_flags;
  logic          w_condex;

  // One-hot bank select; an out-of-range index selects nothing.
  for (genvar b = 0; b < NBANK; b++) begin : g_sel
    assign w_sel[b] = (bus.BankSel == BW'(b));
  end

  // Active-bank flag read mux; reads zero when no bank is selected.
  always_comb begin
    w_flags = '0;
    for (int b = 0; b < NBANK; b++)
      if (w_sel[b]) w_flags = r_flags[b];
  end

  condeval u_condeval (
    .i_cond   (bus.Cond),
    .i_flags  (w_flags),
    .o_condex (w_condex)
  );

  // Banked flag/saved update; restore beats the ALU write, save sees the old flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NBANK; b++) begin
        r_flags[b] <= '0;
        r_saved[b] <= '0;
      end
    end else if (!bus.Stall) begin
      for (int b = 0; b < NBANK; b++) begin
        if (w_sel[b]) begin
          if (bus.FlagRestore) begin
            r_flags[b] <= r_saved[b];
          end else begin
            if (bus.FlagW[1] & w_condex) {r_flags[b].n, r_flags[b].z} <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] & w_condex) {r_flags[b].c, r_flags[b].v} <= bus.ALUFlags[1:0];
          end
          if (bus.FlagSave) r_saved[b] <= r_flags[b];
        end
      end
    end
  end

  // Registered condition result, frozen while the data phase stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_condex_d <= 1'b0;
    else if (!bus.Stall) r_condex_d <= w_condex;
  end

  // Memory-write hold: keep the strobe up until the bus accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else begin
      case (r_state)
        IDLE:    if (bus.MemW & r_condex_d & bus.Stall) r_state <= HOLD;
        HOLD:    if (!bus.Stall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Flags         = w_flags;
  assign bus.CondEx        = w_condex;
  assign bus.CondExDelayed = r_condex_d;
  assign bus.RegWrite      = bus.RegW & r_condex_d & ~bus.NoWrite & ~bus.Stall;
  assign bus.PCWrite       = ((bus.PCS & r_condex_d) | bus.NextPC) & ~bus.Stall;
  assign bus.MemWrite      = (bus.MemW & r_condex_d) | (r_state == HOLD);
endmodule

// File: tb/tb_condlogic_banked.sv
// Directed bench for condlogic_banked (NBANK=2).
module tb_condlogic_banked;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  condlogic_banked_if #(.NBANK(2)) bus();

  condlogic_banked #(.NBANK(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic alu_write(input logic [3:0] f);
    bus.Cond = 4'hE; bus.FlagW = 2'b11; bus.ALUFlags = f;
    step();
    bus.FlagW = 2'b00;
  endtask

  initial begin
    bus.Cond = 4'hE; bus.ALUFlags = '0; bus.FlagW = '0; bus.PCS = 0;
    bus.NextPC = 1; bus.RegW = 0; bus.MemW = 0; bus.NoWrite = 0;
    bus.Stall = 0; bus.BankSel = '0; bus.FlagSave = 0; bus.FlagRestore = 0;

    // Reset state
    #2;
    chk("rst_flags", 8'(bus.Flags), 8'h0);
    chk("rst_pcwrite", 8'(bus.PCWrite), 8'h1);
    chk("rst_regwrite", 8'(bus.RegWrite), 8'h0);
    chk("rst_memwrite", 8'(bus.MemWrite), 8'h0);
    chk("rst_condexd", 8'(bus.CondExDelayed), 8'h0);
    step();
    reset_n = 1'b1;
    bus.NextPC = 0;

    // Flags 1010 plus a pending memory write, then async reset mid-cycle
    bus.MemW = 1;
    alu_write(4'b1010);
    chk("pre_rst_flags", 8'(bus.Flags), 8'hA);
    chk("pre_rst_memwrite", 8'(bus.MemWrite), 8'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_flags", 8'(bus.Flags), 8'h0);
    chk("async_rst_memwrite", 8'(bus.MemWrite), 8'h0);
    reset_n = 1'b1;
    bus.MemW = 0; bus.RegW = 1; bus.Cond = 4'hE;
    #1;
    chk("post_rst_regwrite0", 8'(bus.RegWrite), 8'h0);
    step();
    chk("post_rst_regwrite1", 8'(bus.RegWrite), 8'h1);
    bus.NoWrite = 1;
    #1;
    chk("nowrite_gate", 8'(bus.RegWrite), 8'h0);
    bus.NoWrite = 0; bus.RegW = 0;

    // Flag gating by CondEx
    alu_write(4'b0100);
    chk("gate_write", 8'(bus.Flags), 8'h4);
    bus.Cond = 4'h1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0000;
    #1;
    chk("gate_condex", 8'(bus.CondEx), 8'h0);
    step();
    chk("gate_hold", 8'(bus.Flags), 8'h4);
    chk("gate_condexd", 8'(bus.CondExDelayed), 8'h0);
    bus.FlagW = 2'b00;

    // Partial write: only C,V
    bus.Cond = 4'hE; bus.FlagW = 2'b01; bus.ALUFlags = 4'b1011;
    step();
    chk("partial_cv", 8'(bus.Flags), 8'h7);
    bus.FlagW = 2'b00;

    // Banking
    alu_write(4'b1000);
    chk("bank0_write", 8'(bus.Flags), 8'h8);
    bus.BankSel = 1'b1;
    #1;
    chk("bank1_reset", 8'(bus.Flags), 8'h0);
    alu_write(4'b0011);
    chk("bank1_write", 8'(bus.Flags), 8'h3);
    bus.BankSel = 1'b0;
    #1;
    chk("bank0_back", 8'(bus.Flags), 8'h8);

    // Save / restore
    alu_write(4'b0110);
    bus.FlagSave = 1; step(); bus.FlagSave = 0;
    alu_write(4'b0001);
    chk("sr_overwrite", 8'(bus.Flags), 8'h1);
    bus.FlagRestore = 1; step(); bus.FlagRestore = 0;
    chk("sr_restore", 8'(bus.Flags), 8'h6);

    // Swap: flags=0110, saved=1001
    alu_write(4'b1001);
    bus.FlagSave = 1; step(); bus.FlagSave = 0;
    alu_write(4'b0110);
    bus.FlagSave = 1; bus.FlagRestore = 1; step();
    bus.FlagSave = 0;
    chk("swap_flags", 8'(bus.Flags), 8'h9);
    step(); bus.FlagRestore = 0;
    chk("swap_saved", 8'(bus.Flags), 8'h6);

    // Stall freezes flags
    bus.Stall = 1;
    alu_write(4'b1111);
    chk("stall_flags", 8'(bus.Flags), 8'h6);
    bus.Stall = 0;

    // Stall hold of a memory write
    bus.Cond = 4'hE; step();
    bus.MemW = 1; bus.Stall = 1; bus.RegW = 1; bus.PCS = 1; bus.Cond = 4'hF;
    #1;
    chk("hold_c1_mem", 8'(bus.MemWrite), 8'h1);
    chk("hold_c1_reg", 8'(bus.RegWrite), 8'h0);
    chk("hold_c1_pc", 8'(bus.PCWrite), 8'h0);
    step();
    bus.MemW = 0;
    #1;
    chk("hold_c2_mem", 8'(bus.MemWrite), 8'h1);
    chk("hold_c2_reg", 8'(bus.RegWrite), 8'h0);
    chk("hold_c2_pc", 8'(bus.PCWrite), 8'h0);
    step();
    chk("hold_c3_mem", 8'(bus.MemWrite), 8'h1);
    chk("hold_c3_pc", 8'(bus.PCWrite), 8'h0);
    chk("hold_condexd", 8'(bus.CondExDelayed), 8'h1);
    bus.Stall = 0;
    #1;
    chk("accept_mem", 8'(bus.MemWrite), 8'h1);
    chk("accept_reg", 8'(bus.RegWrite), 8'h1);
    step();
    chk("release_mem", 8'(bus.MemWrite), 8'h0);
    chk("release_condexd", 8'(bus.CondExDelayed), 8'h0);
    bus.RegW = 0; bus.PCS = 0;

    // Condition sweep
    for (int f = 0; f < 16; f++) begin
      alu_write(4'(f));
      for (int c = 0; c < 16; c++) begin
        bus.Cond = 4'(c);
        #1;
        chk($sformatf("cond_%0h_nzcv_%0h", c, f), 8'(bus.CondEx), 8'(ref_cond(4'(c), 4'(f))));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/condlogic_banked.md
# condlogic_banked

Parametrised conditional-execution unit for the multicycle ARM core on the AHB bus. It evaluates the instruction condition against NZCV, gates the register, memory and PC write strobes, and keeps one NZCV register plus one saved-NZCV register per flag bank (mode banking). It also freezes all architectural state while the AHB data phase is stalled, and holds a memory write stable until the bus accepts it.

## Interface
- NBANK, default 2: number of flag banks (≥1); bank index width BW = max(1, $clog2(NBANK)).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagW  in  2  [1]: write N,Z; [0]: write C,V.
- PCS, NextPC, RegW, MemW, NoWrite  in  1 each  controller write requests.
- Stall  in  1  AHB data phase not ready (~HREADY).
- BankSel  in  BW  active flag bank.
- FlagSave  in  1  copy the active bank's flags to its saved register.
- FlagRestore  in  1  copy the active bank's saved register to its flags.
- Flags  out  4  NZCV of the active bank.
- CondEx  out  1  combinational condition result.
- CondExDelayed  out  1  registered CondEx.
- PCWrite, RegWrite, MemWrite  out  1 each  gated strobes.

## Operation
- Reset (async, reset_n=0): all flag and saved registers are 0, CondExDelayed is 0, and the write FSM is in IDLE. Resulting outputs: Flags=0, PCWrite=NextPC&~Stall, RegWrite=0, MemWrite=0.
- Condition evaluation uses Flags:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL(1110)=1; 1111=0.
- Flag update, active bank only, only when Stall=0:
  - FlagRestore=1: flags ← saved. This has priority over the ALU write.
  - Otherwise flags[3:2] ← ALUFlags[3:2] if FlagW[1]&CondEx; flags[1:0] ← ALUFlags[1:0] if FlagW[0]&CondEx.
  - FlagSave=1: saved ← flags, using the pre-update value from the same cycle.
  - FlagSave and FlagRestore together perform a swap.
  - Inactive banks never change.
- CondExDelayed ← CondEx when Stall=0; it holds when Stall=1.
- Combinational strobes:
  - RegWrite = RegW & CondExDelayed & ~NoWrite & ~Stall.
  - PCWrite = ((PCS & CondExDelayed) | NextPC) & ~Stall.
  - MemWrite = (MemW & CondExDelayed) | (state==HOLD).
- Write FSM:
  - IDLE → HOLD when MemW & CondExDelayed & Stall.
  - HOLD → IDLE when Stall=0.
  - MemWrite stays 1 throughout HOLD regardless of MemW.
  - No new write is tracked in HOLD.
- An out-of-range BankSel (NBANK not a power of 2) reads Flags=0 and writes nothing.

## Timing
- CondEx and Flags: combinational from the current bank registers.
- Flag, saved and CondExDelayed updates: visible 1 cycle after the enabling edge.
- MemWrite held through any number of stall cycles. It drops in the first cycle after the accepting edge unless MemW&CondExDelayed is re-asserted.
- BankSel change: Flags and CondEx follow in the same cycle.
- reset_n deassertion: synchronised externally. The first active edge after release behaves as normal.

## Structure
- condlogic_pkg holds:
  - cond_e enum of the 16 condition codes;
  - nzcv_t packed struct {n,z,c,v};
  - wrstate_e {IDLE, HOLD}.
- Sub-module condeval(Cond, Flags → CondEx) is purely combinational and reused by later pipelined cores.
- Flag banks are an array of nzcv_t indexed by BankSel. The FSM and registers live in the top module.

## Test plan
- Reset: assert reset_n=0 mid-cycle with flags=1010 → Flags=0 and MemWrite=0 immediately. After release, Cond=AL, RegW=1 → RegWrite=1 one cycle later.
- Flag gating: ALUFlags=0100, FlagW=11, Cond=AL → Flags=0100. Next, Cond=NE, FlagW=11, ALUFlags=0000 → Flags stays 0100, CondEx=0.
- Banking: bank0 written 1000; BankSel=1, ALU write 0011 → Flags=0011. Switch back to BankSel=0 → Flags=1000.
- Save/restore: bank0 flags=0110; FlagSave, then ALU write 0001, then FlagRestore → Flags=0110. FlagSave+FlagRestore together on flags=0110, saved=1001 → flags=1001, saved=0110.
- Stall hold: MemW=1, CondExDelayed=1, Stall=1 for 3 cycles with MemW dropped after cycle 1 → MemWrite=1 for all 3 cycles and RegWrite=PCWrite=0. Stall=0 → FSM returns to IDLE and MemWrite=0 next cycle.
- Condition sweep: all 16 Cond codes × all 16 NZCV values vs a reference model. Cond=1111 → CondEx=0 for every NZCV value.
